parking_gate_controller: RTL and testbench
==========================================

// Module: parking_gate_controller
// PURPOSE
// - Sequences the entry and exit gates of the car park and keeps the authoritative slot-occupancy vector.
// - Arbitrates between simultaneous entry and exit requests, allocates the lowest free slot on entry and frees the named slot on exit.
// - Drives the gates for a fixed number of cycles.
// - Feeds the occupancy vector to the existing ones_counter to report the parked-car count.
// PARAMETERS
// - SLOTS            8   number of parking slots (occupancy vector width)
// - SLOT_W           3   slot index width, clog2(SLOTS)
// - CNT_W            4   parked-count width, clog2(SLOTS+1)
// - GATE_OPEN_CYCLES 4   cycles a gate stays open per granted car, >=1
// PORTS
// - clk          in   1       system clock, rising edge
// - rst_n        in   1       synchronous reset, active-low
// - entry_req    in   1       car waiting at entry; level, held until entry_grant or entry_reject
// - exit_req     in   1       car waiting at exit; level, held until exit_ack or exit_error
// - exit_slot    in   SLOT_W  slot being vacated; valid while exit_req=1
// - entry_grant  out  1       1-cycle pulse: entry accepted
// - entry_slot   out  SLOT_W  slot assigned to the car; valid in the entry_grant cycle
// - entry_reject out  1       1-cycle pulse: entry refused because the park is full
// - exit_ack     out  1       1-cycle pulse: exit accepted
// - exit_error   out  1       1-cycle pulse: exit_slot was already free
// - gate_in_open out  1       entry gate actuator
// - gate_out_open out 1       exit gate actuator
// - occupancy    out  SLOTS   registered; bit i=1 means slot i is occupied
// - parked       out  CNT_W   popcount(occupancy), combinational from occupancy
// - full         out  1       occupancy all ones, combinational
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge)
//   - All pulses and gates go to 0; occupancy=0; parked=0; full=0.
//   - FSM goes to IDLE; last_served=EXIT, so ENTRY wins the first tie.
//   - Reset mid-operation aborts any open gate immediately.
// - FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN. A down-counter gate_cnt is loaded with GATE_OPEN_CYCLES-1.
// - IDLE
//   - Candidates: entry if entry_req=1; exit if exit_req=1.
//   - Both candidates present: the one not equal to last_served wins (round-robin). The loser keeps waiting.
//   - Entry wins and full=0: pulse entry_grant; entry_slot=lowest-index 0 bit; set that bit in occupancy.
//     Load gate_cnt, go to ENTRY_OPEN, last_served=ENTRY.
//   - Entry wins and full=1: pulse entry_reject; no state change; stay in IDLE; last_served=ENTRY.
//   - Exit wins and occupancy[exit_slot]=1: pulse exit_ack; clear that bit.
//     Load gate_cnt, go to EXIT_OPEN, last_served=EXIT.
//   - Exit wins and occupancy[exit_slot]=0: pulse exit_error; no state change; stay in IDLE; last_served=EXIT.
//   - Occupancy update is registered and is visible the cycle after the grant or ack. Latency req->grant = 1 cycle when uncontended.
// - ENTRY_OPEN / EXIT_OPEN
//   - The matching gate output is 1 for exactly GATE_OPEN_CYCLES cycles, starting the cycle after the grant or ack.
//   - Decrement gate_cnt each cycle; at 0 return to IDLE with the gate closing in the same transition.
//   - Requests are ignored while a gate is open. At most one gate is open at any time.
// - Requesters must drop req the cycle after their pulse. A req still high in IDLE is treated as a new car.
// - parked is computed in CNT_W bits, so there is no overflow: SLOTS=8 gives a maximum of 8 (4'b1000).
// - Only the controller writes occupancy, so parked never exceeds SLOTS and exit never underflows.
// STRUCTURE
// - Shared package/header parking_pkg.vh
//   - FSM state localparams ST_IDLE, ST_ENTRY_OPEN, ST_EXIT_OPEN (2-bit).
//   - SLOTS, SLOT_W, CNT_W defaults.
// - Sub-module slot_allocator: combinational lowest-free-slot priority encoder, occupancy -> {found, slot}.
// - Instantiates the existing ones_counter (occupancy -> parked). No new counter logic.
// TESTING
// - Reset then entry_req=1 -> entry_grant at cycle 1 with entry_slot=0.
//   Occupancy goes to 8'h01 and parked=1; gate_in_open high for cycles 2..5.
// - Eight sequential entries -> slots 0..7 assigned in order; occupancy=8'hFF, full=1, parked=8.
//   A ninth entry -> entry_reject pulse; occupancy unchanged.
// - With occupancy=8'h0F, entry_req and exit_req (exit_slot=2) raised together and last_served=ENTRY
//   -> exit_ack first; occupancy=8'h0B.
//   Entry is granted after that gate closes, with entry_slot=2 and occupancy=8'h0F.
// - With occupancy=8'h01, exit_req with exit_slot=5 -> exit_error pulse; occupancy stays 8'h01; no gate opens.
// - Reset asserted during ENTRY_OPEN (cnt=2) -> next edge: gate_in_open=0, occupancy=0, parked=0, FSM=IDLE.
// - Requests held high during EXIT_OPEN -> no grant, ack or pulse until IDLE.
//   Check gate_in_open&gate_out_open is never 1, and parked==popcount(occupancy) every cycle.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and default sizes for the car-park gate controller.
package parking_pkg;

   localparam int DEF_SLOTS            = 8;
   localparam int DEF_SLOT_W           = 3;
   localparam int DEF_CNT_W            = 4;
   localparam int DEF_GATE_OPEN_CYCLES = 4;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ENTRY_OPEN = 2'd1,
      ST_EXIT_OPEN  = 2'd2
   } gate_state_t;

   typedef enum logic {
      SRV_ENTRY = 1'b0,
      SRV_EXIT  = 1'b1
   } served_t;

   // Gate down-counter width; a single open cycle still needs one bit.
   function automatic int gate_cnt_width(input int cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/ones_counter.sv
// Population count of a bit vector, used to report the number of parked cars.
module ones_counter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + CNT_W'(data[i]);
      end
   end

endmodule

// File: rtl/slot_allocator.sv
// Priority encoder that finds the lowest-index free slot in the occupancy vector.
module slot_allocator
   import parking_pkg::*;
#(
   parameter int SLOTS  = DEF_SLOTS,
   parameter int SLOT_W = DEF_SLOT_W
) (
   input  logic [SLOTS-1:0]  occupancy,
   output logic              found,
   output logic [SLOT_W-1:0] slot
);

   // Scan downwards so the last hit written is the lowest free index.
   always_comb begin
      found = 1'b0;
      slot  = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!occupancy[i]) begin
            found = 1'b1;
            slot  = SLOT_W'(i);
         end
      end
   end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit gate sequencer with round-robin arbitration and the master occupancy vector.
module parking_gate_controller
   import parking_pkg::*;
#(
   parameter int SLOTS            = DEF_SLOTS,
   parameter int SLOT_W           = DEF_SLOT_W,
   parameter int CNT_W            = DEF_CNT_W,
   parameter int GATE_OPEN_CYCLES = DEF_GATE_OPEN_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              entry_req,
   input  logic              exit_req,
   input  logic [SLOT_W-1:0] exit_slot,
   output logic              entry_grant,
   output logic [SLOT_W-1:0] entry_slot,
   output logic              entry_reject,
   output logic              exit_ack,
   output logic              exit_error,
   output logic              gate_in_open,
   output logic              gate_out_open,
   output logic [SLOTS-1:0]  occupancy,
   output logic [CNT_W-1:0]  parked,
   output logic              full
);

   localparam int                GCNT_W    = gate_cnt_width(GATE_OPEN_CYCLES);
   localparam logic [GCNT_W-1:0] GCNT_LOAD = GCNT_W'(GATE_OPEN_CYCLES - 1);

   gate_state_t        state_reg, state_next;
   served_t            last_served_reg, last_served_next;
   logic [GCNT_W-1:0]  gate_cnt_reg, gate_cnt_next;
   logic [SLOTS-1:0]   occupancy_reg, occupancy_next;

   logic               free_found;
   logic [SLOT_W-1:0]  free_slot;
   logic               entry_wins;
   logic               exit_wins;

   slot_allocator #(
      .SLOTS  (SLOTS),
      .SLOT_W (SLOT_W)
   ) u_slot_allocator (
      .occupancy (occupancy_reg),
      .found     (free_found),
      .slot      (free_slot)
   );

   ones_counter #(
      .WIDTH (SLOTS),
      .CNT_W (CNT_W)
   ) u_ones_counter (
      .data  (occupancy_reg),
      .count (parked)
   );

   // On a tie the side that was not served last time goes first.
   assign entry_wins = entry_req && (!exit_req || (last_served_reg == SRV_EXIT));
   assign exit_wins  = exit_req && !entry_wins;

   assign occupancy     = occupancy_reg;
   assign full          = &occupancy_reg;
   assign entry_slot    = free_slot;
   assign gate_in_open  = (state_reg == ST_ENTRY_OPEN);
   assign gate_out_open = (state_reg == ST_EXIT_OPEN);

   always_comb begin
      state_next       = state_reg;
      last_served_next = last_served_reg;
      gate_cnt_next    = gate_cnt_reg;
      occupancy_next   = occupancy_reg;
      entry_grant      = 1'b0;
      entry_reject     = 1'b0;
      exit_ack         = 1'b0;
      exit_error       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // Pulses are suppressed while reset is held so no car is admitted in that cycle.
            if (rst_n && entry_wins) begin
               last_served_next = SRV_ENTRY;
               if (!full) begin
                  entry_grant               = 1'b1;
                  occupancy_next[free_slot] = 1'b1;
                  gate_cnt_next             = GCNT_LOAD;
                  state_next                = ST_ENTRY_OPEN;
               end else begin
                  entry_reject = 1'b1;
               end
            end else if (rst_n && exit_wins) begin
               last_served_next = SRV_EXIT;
               if (occupancy_reg[exit_slot]) begin
                  exit_ack                  = 1'b1;
                  occupancy_next[exit_slot] = 1'b0;
                  gate_cnt_next             = GCNT_LOAD;
                  state_next                = ST_EXIT_OPEN;
               end else begin
                  exit_error = 1'b1;
               end
            end
         end
         ST_ENTRY_OPEN, ST_EXIT_OPEN: begin
            if (gate_cnt_reg == '0) begin
               state_next = ST_IDLE;
            end else begin
               gate_cnt_next = gate_cnt_reg - 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         last_served_reg <= SRV_EXIT;
         gate_cnt_reg    <= '0;
         occupancy_reg   <= '0;
      end else begin
         state_reg       <= state_next;
         last_served_reg <= last_served_next;
         gate_cnt_reg    <= gate_cnt_next;
         occupancy_reg   <= occupancy_next;
      end
   end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed scenarios plus randomized traffic checked cycle by cycle against a car-park model.
module tb_parking_gate_controller;

   localparam int GATE = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic [2:0] exit_slot = 3'd0;
   logic       entry_grant, entry_reject, exit_ack, exit_error;
   logic [2:0] entry_slot;
   logic       gate_in_open, gate_out_open, full;
   logic [7:0] occupancy;
   logic [3:0] parked;

   int total = 0;
   int bad   = 0;

   // Reference model: which slots hold cars, how many gate cycles remain, which gate, who went last.
   logic [7:0] m_occ = 8'h00;
   int         m_busy = 0;
   int         m_kind = 0;
   bit         m_last_entry = 1'b0;

   bit         exp_grant, exp_reject, exp_ack, exp_err;
   logic [2:0] exp_slot;

   parking_gate_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .entry_req     (entry_req),
      .exit_req      (exit_req),
      .exit_slot     (exit_slot),
      .entry_grant   (entry_grant),
      .entry_slot    (entry_slot),
      .entry_reject  (entry_reject),
      .exit_ack      (exit_ack),
      .exit_error    (exit_error),
      .gate_in_open  (gate_in_open),
      .gate_out_open (gate_out_open),
      .occupancy     (occupancy),
      .parked        (parked),
      .full          (full)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare all outputs with the model, then advance the model.
   task automatic step(input logic r, input logic e, input logic x, input logic [2:0] s);
      bit take_entry;
      @(negedge clk);
      rst_n = r; entry_req = e; exit_req = x; exit_slot = s;
      #1;
      exp_grant = 0; exp_reject = 0; exp_ack = 0; exp_err = 0; exp_slot = 3'd0;
      if (r && m_busy == 0) begin
         take_entry = e && (!x || !m_last_entry);
         if (take_entry) begin
            if (m_occ != 8'hFF) begin
               exp_grant = 1;
               for (int i = 7; i >= 0; i--) if (!m_occ[i]) exp_slot = 3'(i);
            end else begin
               exp_reject = 1;
            end
         end else if (x) begin
            if (m_occ[s]) exp_ack = 1;
            else          exp_err = 1;
         end
      end
      chk_eq("gate_in",   gate_in_open,  (m_busy > 0) && (m_kind == 1));
      chk_eq("gate_out",  gate_out_open, (m_busy > 0) && (m_kind == 2));
      chk_eq("gate_excl", gate_in_open & gate_out_open, 0);
      chk_eq("occupancy", occupancy, m_occ);
      chk_eq("parked",    parked, $countones(m_occ));
      chk_eq("full",      full, m_occ == 8'hFF);
      chk_eq("grant",     entry_grant, exp_grant);
      chk_eq("reject",    entry_reject, exp_reject);
      chk_eq("ack",       exit_ack, exp_ack);
      chk_eq("error",     exit_error, exp_err);
      if (exp_grant) begin
         chk_eq("entry_slot", entry_slot, exp_slot);
         $display("t=%0t entry grant slot=%0d", $time, exp_slot);
      end
      if (exp_reject) $display("t=%0t entry reject (park full)", $time);
      if (exp_ack)    $display("t=%0t exit ack slot=%0d", $time, s);
      if (exp_err)    $display("t=%0t exit error slot=%0d", $time, s);
      if (!r) begin
         m_occ = 8'h00; m_busy = 0; m_kind = 0; m_last_entry = 1'b0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) m_kind = 0;
      end else begin
         if (exp_grant || exp_reject) m_last_entry = 1'b1;
         if (exp_ack || exp_err)      m_last_entry = 1'b0;
         if (exp_grant) begin
            m_occ[exp_slot] = 1'b1; m_busy = GATE; m_kind = 1;
         end
         if (exp_ack) begin
            m_occ[s] = 1'b0; m_busy = GATE; m_kind = 2;
         end
      end
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 3'd0);
      step(1'b1, 1'b0, 1'b0, 3'd0);
   endtask

   task automatic do_entry();
      step(1'b1, 1'b1, 1'b0, 3'd0);
      repeat (GATE) step(1'b1, 1'b0, 1'b0, 3'd0);
   endtask

   bit         ent_on, ext_on, ent_gap, ext_gap, r_now;
   logic [2:0] ext_s;
   int         k;

   initial begin
      // Reset, then a single entry: grant in the first cycle, gate open for the next four.
      step(1'b0, 1'b0, 1'b0, 3'd0);
      chk_eq("reset_occ", occupancy, 8'h00);
      chk_eq("reset_parked", parked, 4'd0);
      step(1'b1, 1'b1, 1'b0, 3'd0);
      chk_eq("first_grant", entry_grant, 1'b1);
      chk_eq("first_slot", entry_slot, 3'd0);
      for (int c = 0; c < GATE; c++) begin
         step(1'b1, 1'b0, 1'b0, 3'd0);
         chk_eq("first_gate_open", gate_in_open, 1'b1);
      end
      step(1'b1, 1'b0, 1'b0, 3'd0);
      chk_eq("first_gate_closed", gate_in_open, 1'b0);
      chk_eq("first_occ", occupancy, 8'h01);
      chk_eq("first_parked", parked, 4'd1);

      // Fill the park, then a ninth car is turned away.
      do_reset();
      repeat (8) do_entry();
      chk_eq("fill_occ", occupancy, 8'hFF);
      chk_eq("fill_full", full, 1'b1);
      chk_eq("fill_parked", parked, 4'd8);
      step(1'b1, 1'b1, 1'b0, 3'd0);
      chk_eq("ninth_reject", entry_reject, 1'b1);
      step(1'b1, 1'b0, 1'b0, 3'd0);
      chk_eq("ninth_occ", occupancy, 8'hFF);

      // Tie after an entry: exit goes first, entry waits through the exit gate.
      do_reset();
      repeat (4) do_entry();
      step(1'b1, 1'b1, 1'b1, 3'd2);
      chk_eq("tie_ack", exit_ack, 1'b1);
      chk_eq("tie_no_grant", entry_grant, 1'b0);
      repeat (GATE) step(1'b1, 1'b1, 1'b0, 3'd0);
      chk_eq("tie_occ_after_exit", occupancy, 8'h0B);
      step(1'b1, 1'b1, 1'b0, 3'd0);
      chk_eq("tie_late_grant", entry_grant, 1'b1);
      chk_eq("tie_late_slot", entry_slot, 3'd2);
      repeat (GATE) step(1'b1, 1'b0, 1'b0, 3'd0);
      chk_eq("tie_occ_final", occupancy, 8'h0F);

      // Exit from an empty slot is an error and opens nothing.
      do_reset();
      do_entry();
      step(1'b1, 1'b0, 1'b1, 3'd5);
      chk_eq("bad_exit_error", exit_error, 1'b1);
      step(1'b1, 1'b0, 1'b0, 3'd0);
      chk_eq("bad_exit_gate", gate_out_open, 1'b0);
      chk_eq("bad_exit_occ", occupancy, 8'h01);

      // Reset while the entry gate is open aborts it.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 3'd0);
      step(1'b1, 1'b0, 1'b0, 3'd0);
      step(1'b0, 1'b0, 1'b0, 3'd0);
      step(1'b1, 1'b0, 1'b0, 3'd0);
      chk_eq("abort_gate", gate_in_open, 1'b0);
      chk_eq("abort_occ", occupancy, 8'h00);
      chk_eq("abort_parked", parked, 4'd0);

      // Random traffic obeying the request handshake, with occasional resets.
      ent_on = 0; ext_on = 0; ent_gap = 0; ext_gap = 0; ext_s = 3'd0;
      for (int c = 0; c < 3000; c++) begin
         if (!ent_on && !ent_gap && $urandom_range(0, 3) == 0) ent_on = 1;
         if (!ext_on && !ext_gap && $urandom_range(0, 3) == 0) begin
            ext_on = 1;
            k = $urandom_range(0, 7);
            if (m_occ != 8'h00 && $urandom_range(0, 4) != 0) begin
               while (!m_occ[k]) k = (k + 1) % 8;
            end
            ext_s = 3'(k);
         end
         ent_gap = 0; ext_gap = 0;
         r_now = ($urandom_range(0, 299) != 0);
         step(r_now, ent_on, ext_on, ext_s);
         if (exp_grant || exp_reject) begin ent_on = 0; ent_gap = 1; end
         if (exp_ack || exp_err)      begin ext_on = 0; ext_gap = 1; end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
